// File: rtl/fm_pwm_synth.sv
`default_nettype none
// ============================================================================
// fm_pwm_synth : distance-driven FM tone (slewed NCO, quarter-wave sine, PWM DAC)
// Revision 1.0
// ============================================================================
module fm_pwm_synth #(
  parameter int unsigned     DIST_WIDTH     = 13,
  parameter int unsigned     MAX_DIST       = 2000,
  parameter int unsigned     PHASE_WIDTH    = 32,
  parameter longint unsigned BASE_STEP      = 64'h0000_0000_0100_0000,
  parameter int unsigned     STEP_PER_UNIT  = 16384,
  parameter int unsigned     SLEW           = 0,
  parameter int unsigned     SINE_WIDTH     = 8,
  parameter int unsigned     LUT_ADDR_WIDTH = 8,
  parameter int unsigned     PWM_WIDTH      = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [DIST_WIDTH-1:0] distance,
  input  logic                  distance_valid,
  output logic [SINE_WIDTH-1:0] sample_out,
  output logic                  period_start,
  output logic                  busy,
  output logic                  pwm_out
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_RUN   = 2'd1;
  localparam logic [1:0] c_DRAIN = 2'd2;

  localparam int  c_QN      = 2 ** (LUT_ADDR_WIDTH - 2);
  localparam real c_TWO_PI  = 6.283185307179586;
  localparam real c_NFULL   = real'(2 ** LUT_ADDR_WIDTH);
  localparam real c_AMP     = real'(2 ** (SINE_WIDTH - 1) - 1);

  localparam logic [PHASE_WIDTH-1:0] c_BASE    = PHASE_WIDTH'(BASE_STEP);
  localparam logic [PHASE_WIDTH-1:0] c_SPU     = PHASE_WIDTH'(STEP_PER_UNIT);
  localparam logic [PHASE_WIDTH-1:0] c_SLEW    = PHASE_WIDTH'(SLEW);
  localparam logic [DIST_WIDTH-1:0]  c_MAXD    = DIST_WIDTH'(MAX_DIST);
  localparam logic [PWM_WIDTH-1:0]   c_CNT_MAX = '1;
  localparam logic [SINE_WIDTH-1:0]  c_MID     = {1'b1, {(SINE_WIDTH-1){1'b0}}};

  if (BASE_STEP + 64'(MAX_DIST) * 64'(STEP_PER_UNIT) >= (64'd1 << PHASE_WIDTH)) begin : g_cfg_error
    $error("fm_pwm_synth: BASE_STEP + MAX_DIST*STEP_PER_UNIT overflows the phase step");
  end

  logic [1:0]              state_q, state_d;
  logic [PWM_WIDTH-1:0]    cnt_q, cnt_d;
  logic [PHASE_WIDTH-1:0]  phase_q, phase_d;
  logic [PHASE_WIDTH-1:0]  cur_step_q, cur_step_d;
  logic [PHASE_WIDTH-1:0]  target_step_q, target_step_d;
  logic [SINE_WIDTH-2:0]   tbl_q, tbl_d;
  logic                    neg_q, neg_d;
  logic [SINE_WIDTH-1:0]   sample_q, sample_d;
  logic [PWM_WIDTH-1:0]    duty_q, duty_d;
  logic                    pwm_q, pwm_d;
  logic                    ps_q, ps_d;

  logic                      w_busy;
  logic                      w_cnt_max;
  logic                      w_period_first;
  logic [DIST_WIDTH-1:0]     w_dist_clamped;
  logic [PHASE_WIDTH-1:0]    w_dist_step;
  logic [PHASE_WIDTH-1:0]    w_glide;
  logic [LUT_ADDR_WIDTH-1:0] w_addr;
  logic [LUT_ADDR_WIDTH-3:0] w_idx;
  logic [SINE_WIDTH-2:0]     w_lut [c_QN];
  logic [PWM_WIDTH-1:0]      w_duty;

  assign w_busy         = (state_q != c_IDLE);
  assign w_cnt_max      = (cnt_q == c_CNT_MAX);
  assign w_period_first = (state_q == c_RUN) && (cnt_q == '0);

  // Target step: arithmetic instead of a ROM; a zero target only exists straight after reset.
  assign w_dist_clamped = (distance > c_MAXD) ? c_MAXD : distance;
  assign w_dist_step    = c_BASE + PHASE_WIDTH'(w_dist_clamped) * c_SPU;

  always_comb begin
    target_step_d = target_step_q;
    if (distance_valid) begin
      target_step_d = w_dist_step;
    end else if (target_step_q == '0) begin
      target_step_d = c_BASE;
    end
  end

  if (SLEW == 0) begin : g_jump
    assign w_glide = target_step_q;
  end else begin : g_slew
    logic [PHASE_WIDTH-1:0] w_up;
    logic [PHASE_WIDTH-1:0] w_dn;
    assign w_up    = target_step_q - cur_step_q;
    assign w_dn    = cur_step_q - target_step_q;
    assign w_glide = (target_step_q > cur_step_q)
                   ? cur_step_q + ((w_up > c_SLEW) ? c_SLEW : w_up)
                   : cur_step_q - ((w_dn > c_SLEW) ? c_SLEW : w_dn);
  end

  assign cur_step_d = w_busy ? w_glide : cur_step_q;
  assign phase_d    = w_busy ? phase_q + cur_step_q : phase_q;
  assign cnt_d      = w_busy ? cnt_q + PWM_WIDTH'(1) : '0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE: begin
        if (enable) state_d = c_RUN;
      end
      c_RUN: begin
        if (!enable) state_d = w_cnt_max ? c_IDLE : c_DRAIN;
      end
      c_DRAIN: begin
        if (enable) begin
          state_d = c_RUN;
        end else if (w_cnt_max) begin
          state_d = c_IDLE;
        end
      end
      default: state_d = c_IDLE;
    endcase
  end

  for (genvar gi = 0; gi < c_QN; gi++) begin : g_lut
    localparam real c_ANG = c_TWO_PI * gi / c_NFULL;
    localparam int  c_VAL = $rtoi(c_AMP * $sin(c_ANG) + 0.5);
    assign w_lut[gi] = (SINE_WIDTH-1)'(c_VAL);
  end

  // Quadrant bit 0 mirrors the index within the quarter, bit 1 flips the sign.
  assign w_addr   = phase_q[PHASE_WIDTH-1 -: LUT_ADDR_WIDTH];
  assign w_idx    = w_addr[LUT_ADDR_WIDTH-2] ? ~w_addr[LUT_ADDR_WIDTH-3:0] : w_addr[LUT_ADDR_WIDTH-3:0];
  assign tbl_d    = w_lut[w_idx];
  assign neg_d    = w_addr[LUT_ADDR_WIDTH-1];
  assign sample_d = neg_q ? (c_MID - {1'b0, tbl_q}) : (c_MID + {1'b0, tbl_q});

  // The first cycle of a period already compares against the freshly latched duty.
  assign w_duty = w_period_first ? sample_q[SINE_WIDTH-1 -: PWM_WIDTH] : duty_q;
  assign duty_d = w_duty;
  assign pwm_d  = w_busy && (cnt_q < w_duty);
  assign ps_d   = w_period_first;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= c_IDLE;
      cnt_q         <= '0;
      phase_q       <= '0;
      cur_step_q    <= '0;
      target_step_q <= '0;
      tbl_q         <= '0;
      neg_q         <= 1'b0;
      sample_q      <= '0;
      duty_q        <= '0;
      pwm_q         <= 1'b0;
      ps_q          <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      phase_q       <= phase_d;
      cur_step_q    <= cur_step_d;
      target_step_q <= target_step_d;
      tbl_q         <= tbl_d;
      neg_q         <= neg_d;
      sample_q      <= sample_d;
      duty_q        <= duty_d;
      pwm_q         <= pwm_d;
      ps_q          <= ps_d;
    end
  end

  assign sample_out   = sample_q;
  assign period_start = ps_q;
  assign busy         = w_busy;
  assign pwm_out      = pwm_q;

endmodule
`default_nettype wire

// File: tb/tb_fm_pwm_synth.sv
`default_nettype none
// tb_fm_pwm_synth : two instances (SLEW=0 and SLEW=1e6) driven alike; a cycle-level
// reference model fills per-instance queues that a negedge monitor drains and compares.
module tb_fm_pwm_synth;

  localparam longint unsigned BASE = 64'h0100_0000;
  localparam longint unsigned SPU  = 64'd16384;
  localparam longint unsigned MAXD = 64'd2000;
  localparam longint unsigned MASK = 64'hFFFF_FFFF;

  typedef struct packed {
    logic [7:0]  sample;
    logic        ps;
    logic        busy;
    logic        pwm;
    logic [31:0] tgt;
    logic [31:0] cur;
    logic [31:0] ph;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [12:0] distance = '0;
  logic        distance_valid = 1'b0;
  logic [7:0]  sample0, sample1;
  logic        ps0, ps1, busy0, busy1, pwm0, pwm1;

  int vectors = 0;
  int miscompares = 0;

  obs_t q0[$];
  obs_t q1[$];

  int              m_state[2];
  int              m_cnt[2];
  int              m_sample[2];
  int              m_duty[2];
  bit              m_pwm[2];
  bit              m_ps[2];
  bit              m_seeded[2];
  longint unsigned m_ph[2];
  longint unsigned m_ph_prev[2];
  longint unsigned m_cur[2];
  longint unsigned m_tgt[2];

  fm_pwm_synth #(.SLEW(0)) dut0 (
    .clk(clk), .reset(reset), .enable(enable), .distance(distance),
    .distance_valid(distance_valid), .sample_out(sample0), .period_start(ps0),
    .busy(busy0), .pwm_out(pwm0)
  );

  fm_pwm_synth #(.SLEW(1000000)) dut1 (
    .clk(clk), .reset(reset), .enable(enable), .distance(distance),
    .distance_valid(distance_valid), .sample_out(sample1), .period_start(ps1),
    .busy(busy1), .pwm_out(pwm1)
  );

  always #5 clk = ~clk;

  function automatic longint unsigned slew_of(input int i);
    return (i == 0) ? 64'd0 : 64'd1000000;
  endfunction

  // Offset-binary sine of the top 8 phase bits, quarter-wave mirrored.
  function automatic int sine_sample(input longint unsigned ph);
    int  a, qd, j, idx, mag;
    real x;
    a   = int'((ph >> 24) & 64'hFF);
    qd  = a / 64;
    j   = a % 64;
    idx = (qd % 2 == 1) ? 63 - j : j;
    x   = 127.0 * $sin(2.0 * 3.141592653589793 * idx / 256.0);
    mag = int'($floor(x + 0.5));
    return (qd >= 2) ? 128 - mag : 128 + mag;
  endfunction

  function automatic void model_reset(input int i);
    m_state[i] = 0; m_cnt[i] = 0; m_sample[i] = 0; m_duty[i] = 0;
    m_pwm[i] = 1'b0; m_ps[i] = 1'b0; m_seeded[i] = 1'b0;
    m_ph[i] = 0; m_ph_prev[i] = 0; m_cur[i] = 0; m_tgt[i] = 0;
  endfunction

  function automatic void model_advance(input int i);
    bit              running = (m_state[i] != 0);
    bit              first   = (m_state[i] == 1) && (m_cnt[i] == 0);
    bit              at_end  = (m_cnt[i] == 127);
    int              duty    = first ? m_sample[i] / 2 : m_duty[i];
    longint unsigned step    = m_cur[i];
    longint unsigned slew    = slew_of(i);
    longint unsigned gap;
    longint unsigned d;
    m_pwm[i]     = running && (m_cnt[i] < duty);
    m_ps[i]      = first;
    m_duty[i]    = duty;
    m_sample[i]  = sine_sample(m_ph_prev[i]);
    m_ph_prev[i] = m_ph[i];
    if (running) begin
      m_ph[i] = (m_ph[i] + step) & MASK;
      if (slew == 0) begin
        m_cur[i] = m_tgt[i];
      end else if (m_tgt[i] > step) begin
        gap = m_tgt[i] - step;
        m_cur[i] = step + ((gap > slew) ? slew : gap);
      end else begin
        gap = step - m_tgt[i];
        m_cur[i] = step - ((gap > slew) ? slew : gap);
      end
    end
    if (distance_valid) begin
      d = 64'(distance);
      if (d > MAXD) d = MAXD;
      m_tgt[i] = BASE + d * SPU;
    end else if (!m_seeded[i]) begin
      m_tgt[i] = BASE;
    end
    m_seeded[i] = 1'b1;
    m_cnt[i] = running ? (m_cnt[i] + 1) % 128 : 0;
    case (m_state[i])
      0: if (enable) m_state[i] = 1;
      1: if (!enable) m_state[i] = at_end ? 0 : 2;
      2: begin
        if (enable) m_state[i] = 1;
        else if (at_end) m_state[i] = 0;
      end
      default: m_state[i] = 0;
    endcase
  endfunction

  function automatic obs_t model_obs(input int i);
    obs_t o;
    o.sample = 8'(m_sample[i]);
    o.ps     = m_ps[i];
    o.busy   = (m_state[i] != 0);
    o.pwm    = m_pwm[i];
    o.tgt    = 32'(m_tgt[i]);
    o.cur    = 32'(m_cur[i]);
    o.ph     = 32'(m_ph[i]);
    return o;
  endfunction

  task automatic drive(input bit en, input bit dv, input logic [12:0] d, input bit rst_in);
    @(posedge clk);
    if (!reset) begin
      model_advance(0);
      model_advance(1);
    end
    #1;
    enable = en;
    distance_valid = dv;
    distance = d;
    reset = rst_in;
    if (rst_in) begin
      model_reset(0);
      model_reset(1);
    end
    q0.push_back(model_obs(0));
    q1.push_back(model_obs(1));
  endtask

  task automatic run_to_cnt(input int target, input bit en);
    int n = 0;
    while (m_cnt[0] != target && n < 300) begin
      drive(en, 1'b0, 13'd0, 1'b0);
      n++;
    end
    vectors++;
    if (m_cnt[0] != target) begin
      miscompares++;
      $display("FAIL run_to_cnt: counter %0d, required %0d within 300 cycles", m_cnt[0], target);
    end
  endtask

  task automatic check(input int i, input obs_t want, input obs_t got);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL out%0d t=%0t got sample=%0d ps=%b busy=%b pwm=%b tgt=%h cur=%h ph=%h | required sample=%0d ps=%b busy=%b pwm=%b tgt=%h cur=%h ph=%h",
               i, $time, got.sample, got.ps, got.busy, got.pwm, got.tgt, got.cur, got.ph,
               want.sample, want.ps, want.busy, want.pwm, want.tgt, want.cur, want.ph);
    end
  endtask

  initial begin
    obs_t a0, a1;
    forever begin
      @(negedge clk);
      a0 = {sample0, ps0, busy0, pwm0, dut0.target_step_q, dut0.cur_step_q, dut0.phase_q};
      a1 = {sample1, ps1, busy1, pwm1, dut1.target_step_q, dut1.cur_step_q, dut1.phase_q};
      if (q0.size() > 0) check(0, q0.pop_front(), a0);
      if (q1.size() > 0) check(1, q1.pop_front(), a1);
    end
  end

  function automatic logic [12:0] rand_dist();
    return 13'($urandom_range(0, 8191));
  endfunction

  initial begin
    bit en;
    int len;
    model_reset(0);
    model_reset(1);

    repeat (3) drive(1'b0, 1'b0, 13'd0, 1'b1);
    repeat (2) drive(1'b0, 1'b0, 13'd0, 1'b0);

    // Slow tone from distance 0: full sine sweep and duty extremes.
    drive(1'b1, 1'b1, 13'd0, 1'b0);
    repeat (600) drive(1'b1, 1'b0, rand_dist(), 1'b0);

    drive(1'b1, 1'b1, 13'd5000, 1'b0);
    repeat (60) drive(1'b1, 1'b0, 13'd0, 1'b0);

    // Glide up and down by 1,638,400.
    drive(1'b1, 1'b1, 13'd0, 1'b0);
    repeat (40) drive(1'b1, 1'b0, 13'd0, 1'b0);
    drive(1'b1, 1'b1, 13'd100, 1'b0);
    repeat (6) drive(1'b1, 1'b0, 13'd0, 1'b0);
    drive(1'b1, 1'b1, 13'd0, 1'b0);
    repeat (6) drive(1'b1, 1'b0, 13'd0, 1'b0);

    // Graceful stop from counter 10, then drain to idle.
    run_to_cnt(9, 1'b1);
    drive(1'b0, 1'b0, 13'd0, 1'b0);
    repeat (130) drive(1'b0, 1'b0, 13'd0, 1'b0);

    // Re-raise enable at counter 50 while draining.
    drive(1'b1, 1'b0, 13'd0, 1'b0);
    run_to_cnt(9, 1'b1);
    drive(1'b0, 1'b0, 13'd0, 1'b0);
    run_to_cnt(49, 1'b0);
    drive(1'b1, 1'b0, 13'd0, 1'b0);
    repeat (200) drive(1'b1, 1'b0, 13'd0, 1'b0);

    // Drop enable on the last count: straight to idle.
    run_to_cnt(126, 1'b1);
    drive(1'b0, 1'b0, 13'd0, 1'b0);
    repeat (4) drive(1'b0, 1'b0, 13'd0, 1'b0);

    // Reset asserted while running.
    drive(1'b1, 1'b1, 13'd700, 1'b0);
    repeat (50) drive(1'b1, 1'b0, 13'd0, 1'b0);
    repeat (2) drive(1'b1, 1'b0, 13'd0, 1'b1);
    repeat (5) drive(1'b0, 1'b0, 13'd0, 1'b0);

    for (int seg = 0; seg < 60; seg++) begin
      en  = ($urandom_range(0, 3) != 0);
      len = $urandom_range(1, 120);
      for (int k = 0; k < len; k++) begin
        drive(en, ($urandom_range(0, 19) == 0), rand_dist(), 1'b0);
      end
    end

    @(negedge clk);
    #1;
    vectors++;
    if (q0.size() != 0 || q1.size() != 0) begin
      miscompares++;
      $display("FAIL queue_drain: %0d/%0d entries left, required 0", q0.size(), q1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
